irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Sequential front-end for the 8:3 priority encoder. Captures 8 request lines into a pending register, applies an enable mask and presents the highest-priority pending source as a 3-bit ID.
- Uses a valid/ack handshake toward the consumer (sequencer or interrupt service logic).
- The pending and mask logic and the FSM feed the internal priority-encode stage.

Parameters:
- N_SRC, 8, number of request sources. Fixed at 8 to match the 8:3 encoder; other values are unsupported.
- ID_W, 3, width of the ID output; equals log2(N_SRC).

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  raw request lines, bit 7 = highest priority.
- mask_wr  input  1  load mask register from mask_in this cycle.
- mask_in  input  8  new enable mask; 1 = source enabled.
- ack  input  1  consumer accepts the presented ID.
- ovf_clr  input  1  clear all overflow flags.
- irq_valid  output  1  an ID is presented and held stable.
- irq_id  output  3  presented source index.
- pending  output  8  current pending register, for debug and status.
- ovf  output  8  sticky per-source overflow flags.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, mask=8'hFF, ovf=0.
  - irq_valid=0, irq_id=0, state=IDLE.
  - Reset mid-handshake drops the presented ID; ack in the same cycle as rst is ignored.
- Event capture: an event on source i is a sampled req[i] (see Optional Feature).
  - An event sets pending[i] at that edge.
  - An event on a source whose pending bit is already 1 sets ovf[i].
- Clear: ack while in PRESENT clears pending[irq_id].
  - If a new event arrives on that same source in the same cycle, set wins: pending stays 1 and ovf is not set.
- Overflow flags: ovf_clr clears ovf. An overflow event in the same cycle as ovf_clr wins, so that bit stays 1.
- Mask:
  - mask_wr updates the mask at the edge; the new mask is used from the next cycle.
  - Masked sources still accumulate pending and ovf but are never selected.
- Selection: eligible = pending & mask. sel = index of the highest set bit of eligible; sel=0 when eligible=0.
- FSM, 2 states:
  - IDLE:
    - irq_valid=0.
    - If eligible != 0: register irq_id<=sel, irq_valid<=1, go to PRESENT.
    - ack is ignored.
  - PRESENT:
    - irq_valid=1; irq_id is held stable regardless of new higher-priority events or mask changes (no withdrawal).
    - On ack: clear pending[irq_id], irq_valid<=0, go to IDLE.
    - Exactly one IDLE bubble cycle always follows each ack.
- Latency: event sampled at edge N → pending visible after N → irq_valid=1 after edge N+1. Minimum spacing between successive presentations is 2 cycles.
- irq_id keeps its last value while in IDLE.

Optional Feature:
- Macro: IRQ_PENDING_CTRL_EDGE_EN.
- Defined: an event is a rising edge on req[i], i.e. req[i]=1 and the previous sampled value=0.
  - Adds an 8-bit req_q register, reset to 0.
  - A line held high produces one event only.
- Undefined: level-sensitive. Every cycle with req[i]=1 is an event.
  - A held line re-pends immediately after its ack.
  - A held line sets ovf[i] every cycle while pending[i]=1.

Decomposition:
- Package irq_pkg holds:
  - N_SRC=8 and ID_W=3.
  - State encoding constants ST_IDLE=1'b0, ST_PRESENT=1'b1.
  - Reset constant MASK_RST=8'hFF.
- One sub-module: irq_prio_enc8, a combinational 8:3 highest-bit encoder.
  - Outputs sel[2:0] and any[0]; any=0 when the input is 0.
  - Each input bit k encodes to k exactly.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → irq_valid=0, pending=8'h00, ovf=8'h00, irq_id=0.
- One-cycle pulse req=8'b00001000 → after 2 edges irq_valid=1, irq_id=3. ack → pending=8'h00, irq_valid=0 next cycle.
- Single pulse req=8'b01001110 → presents 6, 3, 2, 1 in that order, one per ack, each separated by a one-cycle bubble. This checks the priority order and that bit 3 encodes as 3.
- mask_wr with mask_in=8'h7F, then pulse req=8'h81 → irq_id=0 only. After ack, pending=8'h80 and irq_valid stays 0. Write mask 8'hFF → irq_id=7.
- While PRESENT with irq_id=2, raise req[7] → irq_id stays 2 until ack, then 7 is presented after the bubble.
- Pulse req[4] twice before ack → ovf=8'h10. Same-cycle ack of ID 4 plus a new req[4] event → pending[4] stays 1, ovf unchanged. ovf_clr → ovf=0.
- Edge mode only: hold req[5]=1 for 10 cycles with acks → exactly one presentation of ID 5.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the pending-interrupt controller.
// The IRQ_PENDING_CTRL_EDGE_EN build option is consumed by irq_pending_ctrl.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  localparam logic [N_SRC-1:0] MASK_RST = 8'hFF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // One-hot select of a single source, used to retire the acknowledged ID.
  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    return N_SRC'(1) << id;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/mask inputs and presented-ID outputs of irq_pending_ctrl.
// Handshake: irq_valid=1 holds irq_id stable; an ID is consumed on a cycle with
// irq_valid && ack, after which irq_valid drops for at least one cycle.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic [N_SRC-1:0] req;
  logic             mask_wr;
  logic [N_SRC-1:0] mask_in;
  logic             ack;
  logic             ovf_clr;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] ovf;
  state_t           state_dbg;

  modport master (
    output req, mask_wr, mask_in, ack, ovf_clr,
    input  irq_valid, irq_id, pending, ovf, state_dbg
  );

  modport slave (
    input  req, mask_wr, mask_in, ack, ovf_clr,
    output irq_valid, irq_id, pending, ovf, state_dbg
  );

endinterface

// File: rtl/irq_prio_enc8.sv
// Combinational 8:3 highest-set-bit encoder; any=0 and sel=0 for an all-zero input.
module irq_prio_enc8
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  output logic [ID_W-1:0]  sel,
  output logic             any
);

  always_comb begin
    sel = '0;
    any = |vec;
    // Ascending scan: the last set bit seen is the highest one.
    for (int k = 0; k < N_SRC; k++) begin
      if (vec[k]) sel = ID_W'(k);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending/mask/overflow front-end with valid/ack presentation of the top source.
// Define IRQ_PENDING_CTRL_EDGE_EN for rising-edge request capture (default: level).
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  irq_pending_ctrl_if.slave  bus
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  irq_id_q, irq_id_nxt;
  logic [N_SRC-1:0] pending_q, mask_q, ovf_q;
  logic [N_SRC-1:0] evt, clr_vec, eligible;
  logic [ID_W-1:0]  sel;
  logic             any;
  logic             ack_take;

`ifdef IRQ_PENDING_CTRL_EDGE_EN
  logic [N_SRC-1:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= bus.req;
  end

  assign evt = bus.req & ~req_q;
`else
  assign evt = bus.req;
`endif

  assign ack_take = (state == ST_PRESENT) && bus.ack;
  assign clr_vec  = ack_take ? id_onehot(irq_id_q) : '0;
  assign eligible = pending_q & mask_q;

  irq_prio_enc8 u_enc (
    .vec (eligible),
    .sel (sel),
    .any (any)
  );

  // A new event beats a same-cycle clear, and a retiring source never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
      ovf_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | evt;
      ovf_q     <= (bus.ovf_clr ? '0 : ovf_q) | (evt & pending_q & ~clr_vec);
      if (bus.mask_wr) mask_q <= bus.mask_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id_q;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_nxt  = ST_PRESENT;
          irq_id_nxt = sel;
        end
      end
      ST_PRESENT: begin
        if (bus.ack) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      irq_id_q <= '0;
    end else begin
      state    <= state_nxt;
      irq_id_q <= irq_id_nxt;
    end
  end

  assign bus.irq_valid = (state == ST_PRESENT);
  assign bus.irq_id    = irq_id_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed and randomized bench for irq_pending_ctrl against a per-source reference model.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  irq_pending_ctrl_if bus ();

  irq_pending_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit [7:0]   m_pend, m_mask, m_ovf, m_prev;
  bit         m_valid;
  int         m_id;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   8'(bus.irq_valid), 8'(m_valid));
    chk({tag, ".state"},   8'(bus.state_dbg), 8'(m_valid));
    chk({tag, ".id"},      8'(bus.irq_id),    8'(m_id));
    chk({tag, ".pending"}, bus.pending,       m_pend);
    chk({tag, ".ovf"},     bus.ovf,           m_ovf);
  endtask

  // Spec rules applied per source to the values present just before the edge.
  task automatic model_edge(input logic r, input logic [7:0] rq, input logic mw,
                            input logic [7:0] mi, input logic a, input logic oc);
    bit [7:0] op;
    bit [7:0] om;
    bit ev, clr, found;
    op = m_pend;
    om = m_mask;
    if (r) begin
      m_pend = '0; m_mask = 8'hFF; m_ovf = '0; m_prev = '0;
      m_valid = 1'b0; m_id = 0;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < 8; i++) begin
`ifdef IRQ_PENDING_CTRL_EDGE_EN
      ev = rq[i] && !m_prev[i];
`else
      ev = rq[i];
`endif
      clr = m_valid && a && (m_id == i);
      if (oc) m_ovf[i] = 1'b0;
      if (ev && op[i] && !clr) m_ovf[i] = 1'b1;
      if (ev) m_pend[i] = 1'b1;
      else if (clr) m_pend[i] = 1'b0;
    end
    m_prev = rq;
    if (!m_valid) begin
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (!found && op[i] && om[i]) begin
          found = 1'b1;
          m_id = i;
          m_valid = 1'b1;
          exp_q.push_back(3'(i));
        end
      end
    end else if (a) begin
      m_valid = 1'b0;
    end
    if (mw) m_mask = mi;
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic mw,
                     input logic [7:0] mi, input logic a, input logic oc);
    logic [2:0] id_before, exp_id;
    logic take;
    @(negedge clk);
    rst = r; bus.req = rq; bus.mask_wr = mw; bus.mask_in = mi;
    bus.ack = a; bus.ovf_clr = oc;
    id_before = bus.irq_id;
    take = m_valid && a && !r;
    @(posedge clk);
    model_edge(r, rq, mw, mi, a, oc);
    if (take) begin
      exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
      chk("ack_id", 8'(id_before), 8'(exp_id));
    end
    #1;
    check_all("cycle");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [7:0] rq);
    cyc(1'b0, rq, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ackc();
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [2:0] seq_ids[3];
    logic [7:0] rq;
    int npres;
    logic a;

    rst = 1'b1;
    bus.req = '0; bus.mask_wr = 1'b0; bus.mask_in = '0; bus.ack = 1'b0; bus.ovf_clr = 1'b0;

    // Reset, with an ack during reset that must be ignored
    cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(5);
    chk("rst_valid", 8'(bus.irq_valid), 8'h00);
    chk("rst_pend",  bus.pending,       8'h00);
    chk("rst_ovf",   bus.ovf,           8'h00);
    chk("rst_id",    8'(bus.irq_id),    8'h00);

    // Single source 3
    pulse(8'b0000_1000);
    chk("s3_pend", bus.pending, 8'h08);
    chk("s3_v0",   8'(bus.irq_valid), 8'h00);
    idle(1);
    chk("s3_v1",   8'(bus.irq_valid), 8'h01);
    chk("s3_id",   8'(bus.irq_id),    8'h03);
    ackc();
    chk("s3_clr",  bus.pending,       8'h00);
    chk("s3_drop", 8'(bus.irq_valid), 8'h00);
    idle(1);

    // Priority order 6,3,2,1 with one bubble after every ack
    pulse(8'b0100_1110);
    idle(1);
    chk("prio_id6", 8'(bus.irq_id), 8'h06);
    seq_ids[0] = 3'd3; seq_ids[1] = 3'd2; seq_ids[2] = 3'd1;
    for (int j = 0; j < 3; j++) begin
      ackc();
      chk("prio_bubble", 8'(bus.irq_valid), 8'h00);
      idle(1);
      chk("prio_v",  8'(bus.irq_valid), 8'h01);
      chk("prio_id", 8'(bus.irq_id),    8'(seq_ids[j]));
    end
    ackc();
    idle(1);
    chk("prio_empty", bus.pending, 8'h00);

    // Masking keeps source 7 pending but unselected
    cyc(1'b0, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0);
    pulse(8'h81);
    idle(1);
    chk("mask_id0", 8'(bus.irq_id), 8'h00);
    ackc();
    chk("mask_pend", bus.pending, 8'h80);
    idle(2);
    chk("mask_quiet", 8'(bus.irq_valid), 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("mask_late", 8'(bus.irq_valid), 8'h00);
    idle(1);
    chk("mask_id7", 8'(bus.irq_id), 8'h07);
    ackc();
    idle(1);

    // No withdrawal by a higher-priority arrival
    pulse(8'h04);
    idle(1);
    chk("hold_id2a", 8'(bus.irq_id), 8'h02);
    pulse(8'h80);
    chk("hold_id2b", 8'(bus.irq_id), 8'h02);
    idle(1);
    chk("hold_id2c", 8'(bus.irq_id), 8'h02);
    ackc();
    chk("hold_bub", 8'(bus.irq_valid), 8'h00);
    idle(1);
    chk("hold_id7", 8'(bus.irq_id), 8'h07);
    ackc();
    idle(1);

    // Overflow, set-wins on same-cycle ack, clear vs. overflow race
    pulse(8'h10);
    idle(1);
    pulse(8'h10);
    chk("ovf_set", bus.ovf, 8'h10);
    idle(1);
    cyc(1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("setwin_pend", bus.pending, 8'h10);
    chk("setwin_ovf",  bus.ovf,     8'h10);
    idle(1);
    chk("setwin_re", 8'(bus.irq_id), 8'h04);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", bus.ovf, 8'h00);
    cyc(1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_race", bus.ovf, 8'h10);
    ackc();
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", bus.ovf, 8'h00);
    idle(2);

    // Held line: one presentation with edge capture, repeated ones with level capture
    npres = 0;
    for (int k = 0; k < 10; k++) begin
      a = bus.irq_valid;
      if (a) npres++;
      cyc(1'b0, 8'h20, 1'b0, 8'h00, a, 1'b0);
    end
`ifdef IRQ_PENDING_CTRL_EDGE_EN
    chk("held_count", 8'(npres), 8'd1);
`else
    chk("held_count", 8'(npres), 8'd4);
    chk("held_ovf",   bus.ovf & 8'h20, 8'h20);
`endif
    for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00, bus.irq_valid, 1'b0);
    chk("held_drain", bus.pending, 8'h00);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rq = '0;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) rq[i] = 1'b1;
      cyc($urandom_range(0, 99) == 0, rq, $urandom_range(0, 15) == 0,
          8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
